// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported, fixed-latency memory between fetch and load/store ports.
// Optional fetch starvation guard is enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_ready,
   output logic              i_rvalid,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [3:0]        d_we,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ready,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_en,
   output logic [3:0]        mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

   if (MEM_LAT < 1) begin : g_bad_lat
      $error("mem_port_arbiter: MEM_LAT must be at least 1");
   end
   if (STARVE_MAX < 1) begin : g_bad_starve
      $error("mem_port_arbiter: STARVE_MAX must be at least 1");
   end

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             grant_i, grant_d;

`ifdef MEM_ARB_STARVE_GUARD_EN
   localparam int STARVE_W = $clog2(STARVE_MAX + 1);
   localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

   logic [STARVE_W-1:0] starve_reg, starve_next;

   // Data normally wins; once fetch has watched STARVE_MAX data grants it takes one turn.
   always_comb begin
      grant_i = 1'b0;
      grant_d = 1'b0;
      if (rst_n && state_reg == IDLE) begin
         if (d_req && !(i_req && starve_reg == STARVE_LIM))
            grant_d = 1'b1;
         else if (i_req)
            grant_i = 1'b1;
      end
   end

   always_comb begin
      starve_next = starve_reg;
      if (grant_i)
         starve_next = '0;
      else if (grant_d)
         starve_next = (i_req && starve_reg != STARVE_LIM) ? starve_reg + 1'b1 : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         starve_reg <= '0;
      else
         starve_reg <= starve_next;
   end
`else
   // Grant is gated by rst_n so every output is 0 while reset is held.
   always_comb begin
      grant_i = 1'b0;
      grant_d = 1'b0;
      if (rst_n && state_reg == IDLE) begin
         if (d_req)
            grant_d = 1'b1;
         else if (i_req)
            grant_i = 1'b1;
      end
   end
`endif

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      i_ready    = 1'b0;
      i_rvalid   = 1'b0;
      i_rdata    = '0;
      d_ready    = 1'b0;
      d_rvalid   = 1'b0;
      d_rdata    = '0;
      mem_en     = 1'b0;
      mem_we     = 4'b0000;
      mem_addr   = '0;
      mem_wdata  = '0;
      case (state_reg)
         IDLE: begin
            if (grant_d) begin
               mem_en    = 1'b1;
               mem_addr  = d_addr;
               mem_we    = d_we;
               mem_wdata = d_wdata;
               d_ready   = 1'b1;
               // Stores produce no response, so the port stays free for the next cycle.
               if (d_we == 4'b0000) begin
                  state_next = BUSY_D;
                  cnt_next   = CNT_LOAD;
               end
            end else if (grant_i) begin
               mem_en     = 1'b1;
               mem_addr   = i_addr;
               i_ready    = 1'b1;
               state_next = BUSY_I;
               cnt_next   = CNT_LOAD;
            end
         end
         BUSY_I: begin
            if (cnt_reg == '0) begin
               i_rvalid   = 1'b1;
               i_rdata    = mem_rdata;
               state_next = IDLE;
            end else begin
               cnt_next = cnt_reg - 1'b1;
            end
         end
         BUSY_D: begin
            if (cnt_reg == '0) begin
               d_rvalid   = 1'b1;
               d_rdata    = mem_rdata;
               state_next = IDLE;
            end else begin
               cnt_next = cnt_reg - 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Drives a MEM_LAT=2 and a MEM_LAT=1 arbiter with identical stimulus and checks every
// output each cycle against a transaction-level reference model.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_req, d_req;
   logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
   logic [3:0]  d_we;

   logic [1:0]  i_ready_w, i_rvalid_w, d_ready_w, d_rvalid_w, mem_en_w;
   logic [31:0] i_rdata_w [2];
   logic [31:0] d_rdata_w [2];
   logic [3:0]  mem_we_w [2];
   logic [31:0] mem_addr_w [2];
   logic [31:0] mem_wdata_w [2];

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Reference model: one outstanding read per instance, described by owner and response cycle.
   int lat [2] = '{2, 1};
   bit pend [2];
   bit pend_d [2];
   int resp_at [2];
   int starve [2];

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) u_lat2 (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready_w[0]), .i_rvalid(i_rvalid_w[0]),
      .i_rdata(i_rdata_w[0]),
      .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata), .d_ready(d_ready_w[0]),
      .d_rvalid(d_rvalid_w[0]), .d_rdata(d_rdata_w[0]),
      .mem_en(mem_en_w[0]), .mem_we(mem_we_w[0]), .mem_addr(mem_addr_w[0]),
      .mem_wdata(mem_wdata_w[0]), .mem_rdata(mem_rdata)
   );

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u_lat1 (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready_w[1]), .i_rvalid(i_rvalid_w[1]),
      .i_rdata(i_rdata_w[1]),
      .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata), .d_ready(d_ready_w[1]),
      .d_rvalid(d_rvalid_w[1]), .d_rdata(d_rdata_w[1]),
      .mem_en(mem_en_w[1]), .mem_we(mem_we_w[1]), .mem_addr(mem_addr_w[1]),
      .mem_wdata(mem_wdata_w[1]), .mem_rdata(mem_rdata)
   );

   task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s lat%0d cyc%0d: observed %h expected %h", tag, lat[k], cyc, obs, exp);
      end
   endtask

   task automatic step(input logic r, input logic iq, input logic [31:0] ia, input logic dq,
                       input logic [31:0] da, input logic [3:0] dwe, input logic [31:0] dwd,
                       input logic [31:0] mrd);
      @(negedge clk);
      rst_n = r; i_req = iq; i_addr = ia; d_req = dq; d_addr = da; d_we = dwe;
      d_wdata = dwd; mem_rdata = mrd;
      #1;
      for (int k = 0; k < 2; k++) begin
         logic        e_ir, e_iv, e_dr, e_dv, e_en;
         logic [31:0] e_ird, e_drd, e_addr, e_wd;
         logic [3:0]  e_we;
         bit          take_d, take_i, force_i;
         e_ir = 0; e_iv = 0; e_dr = 0; e_dv = 0; e_en = 0;
         e_ird = 0; e_drd = 0; e_addr = 0; e_wd = 0; e_we = 0;
         take_d = 0; take_i = 0; force_i = 0;
         if (r && pend[k]) begin
            if (cyc == resp_at[k]) begin
               if (pend_d[k]) begin e_dv = 1; e_drd = mrd; end
               else begin e_iv = 1; e_ird = mrd; end
            end
         end else if (r) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
            force_i = (iq && starve[k] >= 4);
`endif
            if (dq && !force_i) take_d = 1;
            else if (iq) take_i = 1;
            if (take_d) begin
               e_en = 1; e_dr = 1; e_addr = da; e_we = dwe; e_wd = dwd;
            end else if (take_i) begin
               e_en = 1; e_ir = 1; e_addr = ia;
            end
         end
         chk("i_ready",   k, 32'(i_ready_w[k]),  32'(e_ir));
         chk("i_rvalid",  k, 32'(i_rvalid_w[k]), 32'(e_iv));
         chk("i_rdata",   k, i_rdata_w[k],       e_ird);
         chk("d_ready",   k, 32'(d_ready_w[k]),  32'(e_dr));
         chk("d_rvalid",  k, 32'(d_rvalid_w[k]), 32'(e_dv));
         chk("d_rdata",   k, d_rdata_w[k],       e_drd);
         chk("mem_en",    k, 32'(mem_en_w[k]),   32'(e_en));
         chk("mem_we",    k, 32'(mem_we_w[k]),   32'(e_we));
         chk("mem_addr",  k, mem_addr_w[k],      e_addr);
         chk("mem_wdata", k, mem_wdata_w[k],     e_wd);
         if (k == 0)
            $display("cyc%0d rst_n=%0d i_req=%0d d_req=%0d d_we=%b | lat2: en=%0d ir=%0d dr=%0d iv=%0d dv=%0d | lat1: en=%0d ir=%0d dr=%0d iv=%0d dv=%0d",
                     cyc, r, iq, dq, dwe, mem_en_w[0], i_ready_w[0], d_ready_w[0], i_rvalid_w[0],
                     d_rvalid_w[0], mem_en_w[1], i_ready_w[1], d_ready_w[1], i_rvalid_w[1], d_rvalid_w[1]);
         // Advance the model to the state after the coming rising edge.
         if (!r) begin
            pend[k] = 0; starve[k] = 0;
         end else if (pend[k]) begin
            if (cyc == resp_at[k]) pend[k] = 0;
         end else if (take_d) begin
            starve[k] = iq ? starve[k] + 1 : 0;
            if (dwe == 4'b0000) begin pend[k] = 1; pend_d[k] = 1; resp_at[k] = cyc + lat[k]; end
         end else if (take_i) begin
            starve[k] = 0;
            pend[k] = 1; pend_d[k] = 0; resp_at[k] = cyc + lat[k];
         end
      end
      cyc++;
   endtask

   initial begin
      rst_n = 0; i_req = 0; d_req = 0; i_addr = 0; d_addr = 0; d_we = 0; d_wdata = 0; mem_rdata = 0;
      for (int k = 0; k < 2; k++) begin pend[k] = 0; pend_d[k] = 0; resp_at[k] = 0; starve[k] = 0; end
      step(0, 1, 32'h100, 1, 32'h200, 4'h0, 32'h0, 32'h0);
      step(0, 0, 32'h0, 0, 32'h0, 4'h0, 32'h0, 32'h0);

      // Lone fetch, memory returns DEADBEEF.
      step(1, 1, 32'h100, 0, 32'h0, 4'h0, 32'h0, 32'h0);
      step(1, 0, 32'h0,   0, 32'h0, 4'h0, 32'h0, 32'hDEADBEEF);
      step(1, 0, 32'h0,   0, 32'h0, 4'h0, 32'h0, 32'hDEADBEEF);
      step(1, 0, 32'h0,   0, 32'h0, 4'h0, 32'h0, 32'h0);

      // Simultaneous load and fetch: load first, fetch held until it is accepted.
      step(1, 1, 32'h180, 1, 32'h2000, 4'h0, 32'h0, 32'h11111111);
      for (int t = 0; t < 6; t++)
         step(1, 1, 32'h180, 0, 32'h0, 4'h0, 32'h0, 32'h22220000 + 32'(t));

      // Store with fetch held: fetch issues on the very next cycle.
      step(1, 1, 32'h1C0, 1, 32'h40, 4'b0011, 32'h0000BEEF, 32'h0);
      for (int t = 0; t < 4; t++)
         step(1, 1, 32'h1C0, 0, 32'h0, 4'h0, 32'h0, 32'h33330000 + 32'(t));

      // Back-to-back loads held continuously.
      for (int t = 0; t < 7; t++)
         step(1, 0, 32'h0, 1, 32'h800 + 32'(t), 4'h0, 32'h0, 32'h44440000 + 32'(t));

      // Both requests held: data priority, or guarded fetch turn when enabled.
      for (int t = 0; t < 16; t++)
         step(1, 1, 32'h240, 1, 32'h900, 4'h0, 32'h0, 32'h55550000 + 32'(t));
      step(1, 0, 32'h0, 0, 32'h0, 4'h0, 32'h0, 32'h0);
      step(1, 0, 32'h0, 0, 32'h0, 4'h0, 32'h0, 32'h0);

      // Reset in the middle of a load; fetch issues as soon as reset releases.
      step(1, 0, 32'h0, 1, 32'hA00, 4'h0, 32'h0, 32'h0);
      step(0, 0, 32'h0, 0, 32'h0, 4'h0, 32'h0, 32'h66666666);
      step(0, 0, 32'h0, 0, 32'h0, 4'h0, 32'h0, 32'h66666666);
      step(1, 1, 32'h300, 0, 32'h0, 4'h0, 32'h0, 32'h0);
      for (int t = 0; t < 3; t++)
         step(1, 0, 32'h0, 0, 32'h0, 4'h0, 32'h0, 32'h77770000 + 32'(t));

      // Randomised traffic, including stores, dropped requests and occasional resets.
      for (int t = 0; t < 400; t++) begin
         logic [3:0] we;
         we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
         step(($urandom_range(0, 60) != 0), ($urandom_range(0, 2) != 0), $urandom,
              ($urandom_range(0, 2) != 0), $urandom, we, $urandom, $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, fixed-latency unified memory between the instruction-fetch stage and the data (load/store) stage of the RISC-V pipeline.
- Accepts one request per grant and tracks one outstanding read at a time.
- Routes the read response back to the requester that issued it.
- Store byte masks come from the decoder's 4-bit MemWrite field and pass through unchanged.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 2, cycles from memory issue to valid mem_rdata; must be >= 1
- STARVE_MAX, 4, consecutive data grants tolerated while fetch waits (used only with the optional feature)

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- i_req  input  1  fetch request; held with i_addr until i_ready
- i_addr  input  ADDR_W  fetch address
- i_ready  output  1  fetch request accepted this cycle
- i_rvalid  output  1  one-cycle pulse, fetch data valid
- i_rdata  output  DATA_W  fetch data
- d_req  input  1  data request; held with d_addr/d_we/d_wdata until d_ready
- d_addr  input  ADDR_W  data address
- d_we  input  4  byte write mask; 0000 = load
- d_wdata  input  DATA_W  store data
- d_ready  output  1  data request accepted this cycle
- d_rvalid  output  1  one-cycle pulse, load data valid
- d_rdata  output  DATA_W  load data
- mem_en  output  1  memory access issued this cycle
- mem_we  output  4  byte write mask to memory
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  memory write data
- mem_rdata  input  DATA_W  memory read data, valid MEM_LAT cycles after issue

Behaviour:
- Reset: state IDLE, latency counter 0, starvation counter 0. All outputs 0 while rst_n is low. Deassertion is synchronous-safe: the first issue can occur on the first rising edge after release.
- States:
  - IDLE: no read outstanding.
  - BUSY_I: fetch read outstanding.
  - BUSY_D: load read outstanding.
- Grant in IDLE is combinational (Mealy). Default priority is data over fetch, because the data request is older in program order.
- Issue cycle T:
  - mem_en=1; mem_addr, mem_we and mem_wdata are taken from the granted requester. mem_we=0000 and mem_wdata=0 for a fetch.
  - The matching ready output is 1 for exactly this cycle. The ungranted requester sees ready=0 and keeps holding.
- Load or fetch:
  - Move to BUSY_D or BUSY_I; load the counter with MEM_LAT-1.
  - In BUSY, decrement each cycle. At counter==0: the matching rvalid=1, and rdata = mem_rdata (combinational pass-through). Then go to IDLE.
  - Response therefore arrives at T+MEM_LAT. The next issue occurs no earlier than T+MEM_LAT+1.
  - When MEM_LAT=1, the counter loads 0 and rvalid pulses at T+1.
- Store (d_we != 0): no response and no rvalid. Stay in IDLE, so a new issue is possible at T+1.
- No issue while in BUSY. i_ready, d_ready and mem_en are all 0 in BUSY.
- i_rdata and d_rdata are don't-care when the corresponding rvalid=0; they are driven 0.
- A request that drops before ready is simply not serviced; there is no error.
- If rst_n is asserted mid-BUSY, the transaction is aborted: no rvalid is ever produced for it, and the counter clears.

Optional Feature:
- Macro: MEM_ARB_STARVE_GUARD_EN
- Defined:
  - A starvation counter (width clog2(STARVE_MAX+1)) increments on each data grant made while i_req=1.
  - It clears on any fetch grant, or on a data grant while i_req=0.
  - When the counter == STARVE_MAX and both requests are present, fetch is granted instead of data.
- Not defined: strict data priority; the counter logic is absent.

Test Plan:
1. MEM_LAT=2; i_req=1, i_addr=0x100 alone at T -> mem_en=1 and mem_addr=0x100 at T; i_ready=1 at T; i_rvalid=1 with i_rdata=0xDEADBEEF (memory returns that value) at T+2; nothing else pulses.
2. i_req and d_req both asserted at T, d_addr=0x2000, d_we=0000 -> d_ready at T; d_rvalid at T+2; i_ready at T+3 with mem_addr=i_addr; i_rvalid at T+5.
3. Store d_we=0011, d_addr=0x40, d_wdata=0x0000BEEF at T, with i_req held -> mem_we=0011 and mem_wdata=0x0000BEEF at T; no d_rvalid; fetch issued at T+1.
4. MEM_LAT=1, back-to-back loads -> issues at T, T+2, T+4; each d_rvalid at issue+1.
5. With MEM_ARB_STARVE_GUARD_EN, STARVE_MAX=4, d_req and i_req held continuously (loads) -> four data grants, then the fifth grant goes to fetch, then data resumes. Without the macro, fetch is never granted while d_req=1.
6. rst_n pulled low at T+1 of a MEM_LAT=2 load -> all outputs 0 immediately; no d_rvalid at T+2; after release, a new i_req is issued on the first rising edge.
